pkt_gen_ctrl: RTL and testbench

Run-control sequencer for the 16-lane packet generator (128-bit dout, dout_valid).
- On a start command it resets the generator, programs burst length and inter-burst sleep, then enables it.
- It counts valid words and whole packets, stops the generator after N packets, and drains and counts overrun words.
- It reports done, abort and timeout status to the software register interface.

---
 rtl/pkt_gen_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_pkt_gen_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_gen_ctrl.sv
// pkt_gen_ctrl: run-control sequencer for the 16-lane packet generator.
// A software start resets the generator, programs burst length and
// inter-burst sleep, then enables it. Valid words and whole packets are
// counted until the requested number of packets has been produced. After
// that the generator is stopped and any words still in flight are counted
// as overrun. Done, abort and timeout status is reported back to software.
module pkt_gen_ctrl #(
  parameter int unsigned CLR_CYCLES   = 4,      // gen_rst hold time, 1..255
  parameter int unsigned DRAIN_CYCLES = 16,     // overrun window, 1..255
  parameter int unsigned TIMEOUT      = 65536   // RUN watchdog, > max sleep
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_burst_len,
  input  logic [31:0] cfg_sleep_write,
  input  logic [31:0] cfg_num_pkts,
  input  logic        gen_valid,
  output logic        gen_en,
  output logic        gen_rst,
  output logic [31:0] gen_burst_len,
  output logic [31:0] gen_sleep_write,
  output logic        busy,
  output logic        done,
  output logic [31:0] pkts_sent,
  output logic [31:0] words_rcvd,
  output logic [31:0] overrun_words,
  output logic        err_cfg,
  output logic        err_timeout,
  output logic        aborted
);

  // Terminal values of the phase and watchdog counters.
  localparam logic [7:0]  CLR_LAST   = 8'(CLR_CYCLES - 1);
  localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [31:0] WD_LAST    = 32'(TIMEOUT - 1);
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t      state_reg;
  logic [31:0] num_pkts_reg;   // latched packet target
  logic [31:0] word_cnt_reg;   // position inside the current packet
  logic [31:0] wd_cnt_reg;     // RUN cycles since the last valid word
  logic [7:0]  phase_cnt_reg;  // cycles spent in CLEAR or DRAIN

  // Decoded events, all qualified by the current state.
  logic active;       // a run is in progress and may be aborted
  logic abort_hit;    // abort honoured this cycle
  logic accept;       // start accepted with a usable configuration
  logic cfg_reject;   // start refused because burst length is zero
  logic clr_last;     // final CLEAR cycle
  logic run_valid;    // valid word counted during RUN
  logic pkt_end;      // that word completes a packet
  logic last_pkt;     // that packet is the final one requested
  logic wd_fire;      // watchdog expires this cycle
  logic run_exit;     // leave RUN for DRAIN
  logic drain_valid;  // overrun word seen during DRAIN
  logic drain_last;   // final DRAIN cycle

  // Saturating increment so readout never wraps back to small values.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    sat_inc = (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

  // Event decode; abort takes precedence over every in-run transition.
  always_comb begin
    active      = (state_reg == ST_CLEAR) || (state_reg == ST_RUN) ||
                  (state_reg == ST_DRAIN);
    abort_hit   = abort && active;
    accept      = (state_reg == ST_IDLE) && start && (cfg_burst_len != 32'd0);
    cfg_reject  = (state_reg == ST_IDLE) && start && (cfg_burst_len == 32'd0);
    clr_last    = (state_reg == ST_CLEAR) && !abort && (phase_cnt_reg == CLR_LAST);
    run_valid   = (state_reg == ST_RUN) && !abort && gen_valid;
    pkt_end     = run_valid && (word_cnt_reg == gen_burst_len - 32'd1);
    last_pkt    = pkt_end && (pkts_sent == num_pkts_reg - 32'd1);
    wd_fire     = (state_reg == ST_RUN) && !abort && !gen_valid &&
                  (wd_cnt_reg == WD_LAST);
    run_exit    = last_pkt || wd_fire;
    drain_valid = (state_reg == ST_DRAIN) && !abort && gen_valid;
    drain_last  = (state_reg == ST_DRAIN) && !abort && (phase_cnt_reg == DRAIN_LAST);
  end

  // Sequencer: state plus the generator controls and run handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      gen_en    <= 1'b0;
      gen_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        // Stop immediately and give the generator a one-cycle reset.
        state_reg <= ST_IDLE;
        gen_en    <= 1'b0;
        gen_rst   <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            gen_en  <= 1'b0;
            gen_rst <= accept;
            busy    <= accept;
            if (accept) begin
              state_reg <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            if (clr_last) begin
              if (num_pkts_reg == 32'd0) begin
                // Nothing to send: finish without ever enabling.
                state_reg <= ST_DONE;
                done      <= 1'b1;
                busy      <= 1'b0;
              end else begin
                state_reg <= ST_RUN;
                gen_rst   <= 1'b0;
                gen_en    <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (run_exit) begin
              state_reg <= ST_DRAIN;
              gen_en    <= 1'b0;
            end
          end
          ST_DRAIN: begin
            if (drain_last) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
              gen_rst   <= 1'b1;
              busy      <= 1'b0;
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
            gen_rst   <= 1'b0;
          end
          default: begin
            state_reg <= ST_IDLE;
            gen_en    <= 1'b0;
            gen_rst   <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  // Shared CLEAR/DRAIN timer; restarts from zero on entry to either phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_reg <= '0;
    end else if ((state_reg == ST_CLEAR) || (state_reg == ST_DRAIN)) begin
      phase_cnt_reg <= phase_cnt_reg + 8'd1;
    end else begin
      phase_cnt_reg <= '0;
    end
  end

  // Word position within a packet; wraps at each packet boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_reg <= '0;
    end else if (accept || pkt_end) begin
      word_cnt_reg <= '0;
    end else if (run_valid) begin
      word_cnt_reg <= word_cnt_reg + 32'd1;
    end
  end

  // RUN watchdog: zero outside RUN and on every valid word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg <= '0;
    end else if ((state_reg != ST_RUN) || gen_valid) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + 32'd1;
    end
  end

  // Configuration snapshot; held until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_burst_len   <= '0;
      gen_sleep_write <= '0;
      num_pkts_reg    <= '0;
    end else if (accept) begin
      gen_burst_len   <= cfg_burst_len;
      gen_sleep_write <= cfg_sleep_write;
      num_pkts_reg    <= cfg_num_pkts;
    end
  end

  // Run statistics; cleared by an accepted start, held after the run ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkts_sent     <= '0;
      words_rcvd    <= '0;
      overrun_words <= '0;
    end else if (accept) begin
      pkts_sent     <= '0;
      words_rcvd    <= '0;
      overrun_words <= '0;
    end else begin
      if (pkt_end) begin
        pkts_sent <= sat_inc(pkts_sent);
      end
      if (run_valid) begin
        words_rcvd <= sat_inc(words_rcvd);
      end
      if (drain_valid) begin
        overrun_words <= sat_inc(overrun_words);
      end
    end
  end

  // Sticky status flags; a good start clears all three.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
      aborted     <= 1'b0;
    end else if (accept) begin
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      if (cfg_reject) begin
        err_cfg <= 1'b1;
      end
      if (wd_fire) begin
        err_timeout <= 1'b1;
      end
      if (abort_hit) begin
        aborted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_gen_ctrl.sv
// Bench for pkt_gen_ctrl. One process does everything in lock-step on the
// falling edge: it advances a timeline model by the rising edge that just
// passed, compares every DUT output against it, keeps event statistics,
// then drives the generator stand-in for the next cycle.
module tb_pkt_gen_ctrl;

  localparam int CLR  = 4;
  localparam int DRN  = 16;
  localparam int TOUT = 64;

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] cfg_burst_len;
  logic [31:0] cfg_sleep_write;
  logic [31:0] cfg_num_pkts;
  logic        gen_valid;
  logic        gen_en;
  logic        gen_rst;
  logic [31:0] gen_burst_len;
  logic [31:0] gen_sleep_write;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;
  logic [31:0] words_rcvd;
  logic [31:0] overrun_words;
  logic        err_cfg;
  logic        err_timeout;
  logic        aborted;

  pkt_gen_ctrl #(
    .CLR_CYCLES(CLR),
    .DRAIN_CYCLES(DRN),
    .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_burst_len(cfg_burst_len), .cfg_sleep_write(cfg_sleep_write),
    .cfg_num_pkts(cfg_num_pkts), .gen_valid(gen_valid),
    .gen_en(gen_en), .gen_rst(gen_rst), .gen_burst_len(gen_burst_len),
    .gen_sleep_write(gen_sleep_write), .busy(busy), .done(done),
    .pkts_sent(pkts_sent), .words_rcvd(words_rcvd),
    .overrun_words(overrun_words), .err_cfg(err_cfg),
    .err_timeout(err_timeout), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  // Timeline model: phase plus absolute deadlines instead of counters.
  int     m_phase = P_IDLE;
  longint m_deadline = 0, m_last = 0;
  longint m_burst = 0, m_sleep = 0, m_num = 0;
  longint m_pkts = 0, m_words = 0, m_over = 0;
  bit     m_en = 0, m_rst = 0, m_busy = 0, m_done = 0;
  bit     m_err_cfg = 0, m_err_to = 0, m_aborted = 0;

  // Event statistics.
  int     done_total = 0, rst_hi_total = 0, en_hi_total = 0;
  longint last_valid_cyc = 0, en_fall_cyc = 0, done_cyc = 0, to_delta = -1;
  bit     en_prev = 0, to_seen = 0;

  // Generator stand-in.
  int gm_burst = 4, gm_sleep = 10, gm_limit = 1000, gm_extra = 0;
  int gm_pos = 0, gm_emitted = 0, gm_extra_left = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_deadline = 0; m_last = 0;
    m_burst = 0; m_sleep = 0; m_num = 0;
    m_pkts = 0; m_words = 0; m_over = 0;
    m_en = 0; m_rst = 0; m_busy = 0; m_done = 0;
    m_err_cfg = 0; m_err_to = 0; m_aborted = 0;
  endtask

  task automatic model_done();
    m_phase = P_DONE; m_done = 1; m_rst = 1; m_busy = 0;
  endtask

  task automatic model_abort();
    m_phase = P_IDLE; m_en = 0; m_rst = 1; m_busy = 0; m_aborted = 1;
  endtask

  // Advance the model by one rising edge using the inputs it sampled.
  task automatic model_step();
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (gen_valid) last_valid_cyc = cyc;
    m_done = 0;
    case (m_phase)
      P_IDLE: begin
        m_rst = 0;
        if (start) begin
          if (cfg_burst_len == 0) m_err_cfg = 1;
          else begin
            m_burst = cfg_burst_len; m_sleep = cfg_sleep_write; m_num = cfg_num_pkts;
            m_pkts = 0; m_words = 0; m_over = 0;
            m_err_cfg = 0; m_err_to = 0; m_aborted = 0;
            m_phase = P_CLEAR; m_rst = 1; m_busy = 1;
            m_deadline = cyc + CLR;
          end
        end
      end
      P_CLEAR: begin
        if (abort) model_abort();
        else if (cyc == m_deadline) begin
          if (m_num == 0) model_done();
          else begin
            m_phase = P_RUN; m_rst = 0; m_en = 1; m_last = cyc;
          end
        end
      end
      P_RUN: begin
        if (abort) model_abort();
        else if (gen_valid) begin
          m_words = sat32(m_words + 1);
          m_last = cyc;
          if (m_words % m_burst == 0) begin
            m_pkts = m_words / m_burst;
            if (m_pkts == m_num) begin
              m_en = 0; m_phase = P_DRAIN; m_deadline = cyc + DRN;
            end
          end
        end else if (cyc - m_last == TOUT) begin
          m_err_to = 1; m_en = 0; m_phase = P_DRAIN; m_deadline = cyc + DRN;
        end
      end
      P_DRAIN: begin
        if (abort) model_abort();
        else begin
          if (gen_valid) m_over = sat32(m_over + 1);
          if (cyc == m_deadline) model_done();
        end
      end
      default: begin
        m_rst = 0; m_phase = P_IDLE;
      end
    endcase
  endtask

  task automatic compare_all();
    check("gen_en", gen_en, m_en);
    check("gen_rst", gen_rst, m_rst);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("gen_burst_len", gen_burst_len, m_burst);
    check("gen_sleep_write", gen_sleep_write, m_sleep);
    check("pkts_sent", pkts_sent, m_pkts);
    check("words_rcvd", words_rcvd, m_words);
    check("overrun_words", overrun_words, m_over);
    check("err_cfg", err_cfg, m_err_cfg);
    check("err_timeout", err_timeout, m_err_to);
    check("aborted", aborted, m_aborted);
  endtask

  task automatic monitor();
    if (done) begin done_total++; done_cyc = cyc; end
    if (gen_rst) rst_hi_total++;
    if (gen_en) en_hi_total++;
    if (en_prev && !gen_en) en_fall_cyc = cyc;
    en_prev = gen_en;
    if (err_timeout && !to_seen) begin
      to_seen = 1;
      to_delta = cyc - last_valid_cyc;
    end
  endtask

  // Generator: bursts of gm_burst words separated by gm_sleep idle cycles
  // while enabled, optionally running on for gm_extra cycles after disable.
  task automatic gen_step();
    if (gen_en) begin
      if (gm_pos < gm_burst && gm_emitted < gm_limit) begin
        gen_valid = 1'b1;
        gm_emitted++;
      end else begin
        gen_valid = 1'b0;
      end
      gm_pos++;
      if (gm_pos == gm_burst + gm_sleep) gm_pos = 0;
      gm_extra_left = gm_extra;
    end else if (gm_extra_left > 0) begin
      gen_valid = 1'b1;
      gm_extra_left--;
    end else begin
      gen_valid = 1'b0;
      gm_pos = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    compare_all();
    monitor();
    gen_step();
  endtask

  task automatic start_run(input int b, input int s, input int n);
    cfg_burst_len = b; cfg_sleep_write = s; cfg_num_pkts = n;
    gm_emitted = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int base;
    base = done_total;
    for (int i = 0; i < budget && done_total == base; i++) tick();
    check({name, " done_reached"}, done_total - base, 1);
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (words_rcvd < target && i < budget) begin
      tick();
      i++;
    end
    check({name, " words_reached"}, (words_rcvd >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_pkts(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (pkts_sent < target && i < budget) begin
      tick();
      i++;
    end
    check({name, " pkts_reached"}, (pkts_sent >= target) ? 1 : 0, 1);
  endtask

  int b_done, b_rst, b_en;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gen_valid = 1'b0;
    cfg_burst_len = 0; cfg_sleep_write = 0; cfg_num_pkts = 0;
    repeat (3) tick();
    check("reset gen_en", gen_en, 0);
    check("reset gen_rst", gen_rst, 0);
    check("reset busy", busy, 0);
    check("reset pkts_sent", pkts_sent, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: nominal run
    b_done = done_total; b_rst = rst_hi_total;
    gm_burst = 4; gm_sleep = 10; gm_limit = 1000; gm_extra = 0;
    start_run(4, 10, 3);
    wait_done(400, "t1");
    repeat (2) tick();
    check("t1 pkts_sent", pkts_sent, 3);
    check("t1 words_rcvd", words_rcvd, 12);
    check("t1 overrun_words", overrun_words, 0);
    check("t1 done_pulses", done_total - b_done, 1);
    check("t1 gen_rst_cycles", rst_hi_total - b_rst, CLR + 1);
    check("t1 busy_after", busy, 0);

    // 2: overrun words after disable
    gm_extra = 2;
    start_run(4, 10, 3);
    wait_done(400, "t2");
    repeat (2) tick();
    gm_extra = 0;
    check("t2 words_rcvd", words_rcvd, 12);
    check("t2 overrun_words", overrun_words, 2);
    check("t2 drain_length", done_cyc - en_fall_cyc, DRN);

    // 3: abort mid-RUN after 5 words
    b_done = done_total; b_rst = rst_hi_total;
    gm_limit = 5;
    start_run(4, 10, 10);
    wait_words(5, 200, "t3");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    check("t3 aborted", aborted, 1);
    check("t3 pkts_sent", pkts_sent, 1);
    check("t3 words_rcvd", words_rcvd, 5);
    check("t3 done_pulses", done_total - b_done, 0);
    check("t3 gen_rst_cycles", rst_hi_total - b_rst, CLR + 1);
    check("t3 gen_en_after", gen_en, 0);

    // 4: watchdog timeout after 6 words
    gm_limit = 6; to_seen = 0; to_delta = -1;
    start_run(4, 10, 2);
    wait_done(400, "t4");
    repeat (2) tick();
    check("t4 err_timeout", err_timeout, 1);
    check("t4 timeout_delay", to_delta, TOUT);
    check("t4 pkts_sent", pkts_sent, 1);
    check("t4 words_rcvd", words_rcvd, 6);

    // 5a: zero burst length refused
    gm_limit = 1000;
    b_en = en_hi_total;
    start_run(0, 10, 3);
    repeat (3) tick();
    check("t5a err_cfg", err_cfg, 1);
    check("t5a busy", busy, 0);
    check("t5a gen_en_cycles", en_hi_total - b_en, 0);
    check("t5a burst_held", gen_burst_len, 4);

    // 5b: zero packets: CLEAR then DONE
    b_en = en_hi_total; b_done = done_total;
    start_run(4, 10, 0);
    wait_done(50, "t5b");
    repeat (2) tick();
    check("t5b pkts_sent", pkts_sent, 0);
    check("t5b gen_en_cycles", en_hi_total - b_en, 0);
    check("t5b err_cfg_cleared", err_cfg, 0);

    // 5c: start during RUN ignored
    start_run(4, 10, 2);
    wait_pkts(1, 200, "t5c");
    cfg_burst_len = 7; cfg_num_pkts = 9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400, "t5c");
    repeat (2) tick();
    check("t5c gen_burst_len", gen_burst_len, 4);
    check("t5c pkts_sent", pkts_sent, 2);
    check("t5c words_rcvd", words_rcvd, 8);

    // 6: asynchronous reset mid-RUN
    start_run(4, 10, 3);
    wait_words(2, 200, "t6");
    #2 rst_n = 1'b0;
    #1;
    check("t6 async gen_en", gen_en, 0);
    check("t6 async words_rcvd", words_rcvd, 0);
    check("t6 async pkts_sent", pkts_sent, 0);
    check("t6 async busy", busy, 0);
    check("t6 async burst_len", gen_burst_len, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("t6 idle_after", busy, 0);
    gm_burst = 2; gm_sleep = 3;
    start_run(2, 3, 2);
    wait_done(200, "t6");
    repeat (2) tick();
    check("t6 pkts_sent", pkts_sent, 2);
    check("t6 words_rcvd", words_rcvd, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
